// File: rtl/alu_loader_pkg.sv
// Shared types and constants for the ALU operand loader.
// The state encoding doubles as the stage LED value.
package alu_loader_pkg;

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      LOAD_OP = 2'd2,
      SHOW    = 2'd3
   } state_e;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

endpackage

// File: rtl/button_debouncer.sv
// Turns a raw asynchronous push button into a single-cycle press pulse:
// 2-FF synchronizer, stable-count debouncer, rising-edge detect.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic pulse
);

   // The counter only ever holds 0..DEBOUNCE_CYCLES-1; the would-be
   // terminal value is where the level flips and the count restarts.
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic          level_prev_q, level_prev_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d      = btn_raw;
      sync2_d      = sync1_q;
      level_d      = level_q;
      level_prev_d = level_q;
      cnt_d        = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign pulse = level_q & ~level_prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         level_q      <= level_d;
         level_prev_q <= level_prev_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_operand_loader.sv
// Steps through operand A, operand B and opcode entry from board switches,
// one debounced "next" press per stage; "clear" aborts and zeroes everything.
module alu_operand_loader
   import alu_loader_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] switches,
   input  logic             btn_next,
   input  logic             btn_clear,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [3:0]       alu_control,
   output logic [1:0]       stage,
   output logic             result_valid
);

   logic next_pulse, clear_pulse;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_next),
      .pulse   (next_pulse)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_clear),
      .pulse   (clear_pulse)
   );

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [3:0]       op_q, op_d;
   logic             valid_q, valid_d;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      // Clear outranks a coincident next press.
      if (clear_pulse) begin
         state_d = LOAD_A;
         a_d     = '0;
         b_d     = '0;
         op_d    = '0;
      end else if (next_pulse) begin
         case (state_q)
            LOAD_A:  begin a_d  = switches;      state_d = LOAD_B;  end
            LOAD_B:  begin b_d  = switches;      state_d = LOAD_OP; end
            LOAD_OP: begin op_d = switches[3:0]; state_d = SHOW;    end
            default: state_d = LOAD_A;
         endcase
      end
      valid_d = (state_d == SHOW);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         valid_q <= valid_d;
      end
   end

   assign a            = a_q;
   assign b            = b_q;
   assign alu_control  = op_q;
   assign stage        = state_q;
   assign result_valid = valid_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a 4-cycle debounce window.
module tb_alu_operand_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] switches;
   logic       btn_next, btn_clear;
   logic [7:0] a, b;
   logic [3:0] alu_control;
   logic [1:0] stage;
   logic       result_valid;

   int err_cnt = 0;
   int chk_cnt = 0;

   alu_operand_loader #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .switches     (switches),
      .btn_next     (btn_next),
      .btn_clear    (btn_clear),
      .a            (a),
      .b            (b),
      .alu_control  (alu_control),
      .stage        (stage),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Hold the raw button(s) for hold cycles, then release and let the
   // release settle; ends just after a posedge.
   task automatic press(input logic nx, input logic cl, input int hold);
      @(posedge clk); #1;
      btn_next  = nx;
      btn_clear = cl;
      repeat (hold) @(posedge clk);
      #1;
      btn_next  = 1'b0;
      btn_clear = 1'b0;
      repeat (10) @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      switches  = 8'h00;
      btn_next  = 1'b0;
      btn_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_a", a, 0);
      chk("rst_b", b, 0);
      chk("rst_op", alu_control, 0);
      chk("rst_stage", stage, 0);
      chk("rst_valid", result_valid, 0);

      // First press, watching the debounce window from the inside.
      switches = 8'h3C;
      @(posedge clk); #1;
      btn_next = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("lat_early_stage", stage, 0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("lat_done_stage", stage, 1);
      chk("load_a", a, 8'h3C);
      repeat (2) @(posedge clk);
      #1 btn_next = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("hold_one_pulse", stage, 1);

      switches = 8'hA5;
      press(1'b1, 1'b0, 10);
      chk("load_b_stage", stage, 2);
      switches = 8'h02;
      press(1'b1, 1'b0, 10);
      chk("full_a", a, 8'h3C);
      chk("full_b", b, 8'hA5);
      chk("full_op", alu_control, 4'h2);
      chk("full_stage", stage, 3);
      chk("full_valid", result_valid, 1);

      // Wrap from SHOW; registers retained, switches alone do nothing.
      press(1'b1, 1'b0, 10);
      chk("wrap_stage", stage, 0);
      chk("wrap_valid", result_valid, 0);
      chk("wrap_a", a, 8'h3C);
      switches = 8'hFF;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("noprs_a", a, 8'h3C);
      chk("noprs_stage", stage, 0);

      // Glitch too short to register, then a real press.
      press(1'b1, 1'b0, 3);
      chk("glitch_stage", stage, 0);
      chk("glitch_a", a, 8'h3C);
      press(1'b1, 1'b0, 10);
      chk("long_stage", stage, 1);
      chk("long_a", a, 8'hFF);

      // Clear from LOAD_B.
      press(1'b0, 1'b1, 10);
      chk("clr_stage", stage, 0);
      chk("clr_a", a, 0);

      // Coincident clear and next in LOAD_OP.
      switches = 8'h11;
      press(1'b1, 1'b0, 10);
      switches = 8'h22;
      press(1'b1, 1'b0, 10);
      chk("pre_both_stage", stage, 2);
      chk("pre_both_b", b, 8'h22);
      switches = 8'h07;
      press(1'b1, 1'b1, 10);
      chk("both_stage", stage, 0);
      chk("both_a", a, 0);
      chk("both_b", b, 0);
      chk("both_op", alu_control, 0);
      chk("both_valid", result_valid, 0);

      // Reset mid-press with data loaded, button kept held across it.
      switches = 8'h5A;
      press(1'b1, 1'b0, 10);
      chk("pre_rst_a", a, 8'h5A);
      switches = 8'h77;
      @(posedge clk); #1;
      btn_next = 1'b1;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_stage", stage, 0);
      chk("midrst_a", a, 0);
      chk("midrst_valid", result_valid, 0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("midrst_early_stage", stage, 0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("midrst_pulse_stage", stage, 1);
      chk("midrst_pulse_a", a, 8'h77);
      repeat (6) @(posedge clk);
      #1 btn_next = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("midrst_single", stage, 1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 Parameter WIDTH, default 8: operand width, matching the ALU/display datapath.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000: the number of consecutive stable cycles a button must hold before its debounced level changes.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 switches  input  WIDTH  raw board switches; operand/opcode source.
REQ-006 btn_next  input  1  raw, asynchronous, active-high push button; advances entry stage.
REQ-007 btn_clear  input  1  raw, asynchronous, active-high push button; aborts entry.
REQ-008 a  output  WIDTH  registered operand A to the ALU.
REQ-009 b  output  WIDTH  registered operand B to the ALU.
REQ-010 alu_control  output  4  registered ALU opcode.
REQ-011 stage  output  2  current FSM state encoding, for LEDs.
REQ-012 result_valid  output  1  high only when a, b and alu_control are all committed.

Function
REQ-013 Each button passes through a 2-FF synchronizer, then a debouncer.
REQ-014 Debouncer counter: increments while the synchronized level differs from the debounced level; clears to 0 when they are equal.
REQ-015 Debounced level toggles on the cycle the counter would reach DEBOUNCE_CYCLES; the counter clears on the same cycle.
REQ-016 A press pulse is one cycle wide on the debounced 0->1 edge; holding the button yields exactly one pulse; release yields none.
REQ-017 FSM states and encodings: LOAD_A=0, LOAD_B=1, LOAD_OP=2, SHOW=3; stage equals the encoding.
REQ-018 LOAD_A + next pulse: a <= switches; go to LOAD_B.
REQ-019 LOAD_B + next pulse: b <= switches; go to LOAD_OP.
REQ-020 LOAD_OP + next pulse: alu_control <= switches[3:0]; go to SHOW.
REQ-021 SHOW + next pulse: go to LOAD_A; a, b and alu_control hold until overwritten.
REQ-022 result_valid = (state == SHOW), registered, so it rises on the same edge as the state.
REQ-023 Clear pulse in any state: go to LOAD_A and zero a, b and alu_control.
REQ-024 Clear and next pulses in the same cycle: clear wins; the next pulse is discarded.
REQ-025 Without a pulse, the state and all registers hold; switch changes have no effect.
REQ-026 Latency: a raw edge held stable produces the debounced change DEBOUNCE_CYCLES+2 cycles after the first sampling edge; the state and register update occurs 1 cycle later.

Reset
REQ-027 On reset: state=LOAD_A; a=0; b=0; alu_control=0; result_valid=0; synchronizers, debounced levels, counters and edge registers all 0.
REQ-028 Reset asserted mid-press or mid-entry: all state is discarded; a button still held after reset deasserts produces a new pulse after full debounce.

Structure
REQ-029 Package alu_loader_pkg: the state enum (LOAD_A..SHOW) and the DEBOUNCE_CYCLES default constant.
REQ-030 Sub-module button_debouncer (synchronizer, counter, debounced level, rising-edge pulse), instantiated once per button.
REQ-031 Top level: FSM and capture registers only; no arithmetic and no display logic.

Verification (DEBOUNCE_CYCLES=4, WIDTH=8)
REQ-032 Full entry: switches=0x3C, press next; 0xA5, press next; 0x2, press next -> a=0x3C, b=0xA5, alu_control=0x2, stage=3, result_valid=1.
REQ-033 Glitch: btn_next high for 3 cycles, then low -> no state change; high for 10 cycles -> exactly one advance.
REQ-034 Simultaneous clear+next in LOAD_OP (a=0x11, b=0x22) -> stage=0, a=b=alu_control=0, result_valid=0.
REQ-035 Wrap: in SHOW, press next -> stage=0, result_valid=0, a=0x3C retained; switches changed to 0xFF without a press -> a stays 0x3C.
REQ-036 Reset mid-press (btn_next held, counter=2) -> all outputs 0 the next cycle; continued hold -> one pulse after 4 stable cycles.
